hazard_stall_unit: RTL and testbench



---
 rtl/mycpu_pkg.sv | 24 ++
 rtl/hazard_cmp.sv | 29 ++
 rtl/hazard_stall_unit.sv | 104 ++++++++++
 tb/tb_hazard_stall_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the decode-stage hazard interlock.
// HAZARD_WB_BYPASS_EN selects the write-through register file bubble table.
package mycpu_pkg;

    typedef enum logic [0:0] {IDLE, STALL} state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

`ifdef HAZARD_WB_BYPASS_EN
    // Write-through register file: the oldest producer is already visible.
    localparam logic [1:0] BUB_M1 = 2'd2;
    localparam logic [1:0] BUB_M2 = 2'd1;
    localparam logic [1:0] BUB_M3 = 2'd0;
`else
    localparam logic [1:0] BUB_M1 = 2'd3;
    localparam logic [1:0] BUB_M2 = 2'd2;
    localparam logic [1:0] BUB_M3 = 2'd1;
`endif

    function automatic logic [1:0] max_bub(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source register against the three in-flight destinations and
// returns the number of bubbles needed before that source may be read.
module hazard_cmp
    import mycpu_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  logic [4:0] m1_i,
    input  logic [4:0] m2_i,
    input  logic [4:0] m3_i,
    output logic [1:0] bub_o
);

    logic live;

    always_comb begin
        live  = used_i && (src_i != REG_ZERO);
        bub_o = 2'd0;
        // Nearest producer has the largest requirement, so priority gives the max.
        if (live && (src_i == m1_i)) begin
            bub_o = BUB_M1;
        end else if (live && (src_i == m2_i)) begin
            bub_o = BUB_M2;
        end else if (live && (src_i == m3_i)) begin
            bub_o = BUB_M3;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage RAW interlock: holds IF/ID and injects bubbles until the producer
// is far enough ahead. Bubble table switches with HAZARD_WB_BYPASS_EN.
module hazard_stall_unit
    import mycpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_dest,
    input  logic [4:0]       tRegOfMinus1Inst,
    input  logic [4:0]       tRegOfMinus2Inst,
    input  logic [4:0]       tRegOfMinus3Inst,
    output logic             stall,
    output logic [4:0]       targetReg,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [1:0]       rs_bub, rt_bub, need;

    hazard_cmp u_cmp_rs (
        .src_i  (id_rs),
        .used_i (id_rs_used & id_valid),
        .m1_i   (tRegOfMinus1Inst),
        .m2_i   (tRegOfMinus2Inst),
        .m3_i   (tRegOfMinus3Inst),
        .bub_o  (rs_bub)
    );

    hazard_cmp u_cmp_rt (
        .src_i  (id_rt),
        .used_i (id_rt_used & id_valid),
        .m1_i   (tRegOfMinus1Inst),
        .m2_i   (tRegOfMinus2Inst),
        .m3_i   (tRegOfMinus3Inst),
        .bub_o  (rt_bub)
    );

    assign need = max_bub(rs_bub, rt_bub);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        targetReg = REG_ZERO;
        if (id_flush) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        // The current cycle is the first bubble; cnt tracks the rest.
                        if (need > 2'd1) begin
                            cnt_d   = need - 2'd1;
                            state_d = STALL;
                        end
                    end else begin
                        targetReg = id_valid ? id_dest : REG_ZERO;
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
        stall_cycles_d = stall_cycles_q + CNT_W'(stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit; history slots are driven
// by hand as the downstream tracker would shift them.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_flush = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic [4:0]  m1 = '0, m2 = '0, m3 = '0;
    logic        stall;
    logic [4:0]  targetReg;
    logic [31:0] stall_cycles;

    typedef struct {
        string       name;
        logic        stall;
        logic [4:0]  tgt;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] sc_model = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_flush         (id_flush),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rs_used       (id_rs_used),
        .id_rt_used       (id_rt_used),
        .id_dest          (id_dest),
        .tRegOfMinus1Inst (m1),
        .tRegOfMinus2Inst (m2),
        .tRegOfMinus3Inst (m3),
        .stall            (stall),
        .targetReg        (targetReg),
        .stall_cycles     (stall_cycles)
    );

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic step(input string name, input logic r, input logic v, input logic f,
                        input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] dst, input logic [4:0] h1,
                        input logic [4:0] h2, input logic [4:0] h3,
                        input logic e_stall, input logic [4:0] e_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_flush = f;
        id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu; id_dest = dst;
        m1 = h1; m2 = h2; m3 = h3;
        if (r) sc_model = 0;
        e.name = name; e.stall = e_stall; e.tgt = e_tgt; e.sc = sc_model;
        sb.push_back(e);
        if (e_stall && !r) sc_model = sc_model + 1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (stall === e.stall && targetReg === e.tgt && stall_cycles === e.sc) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%0b targetReg=%0d stall_cycles=%0d, want stall=%0b targetReg=%0d stall_cycles=%0d",
                         e.name, stall, targetReg, stall_cycles, e.stall, e.tgt, e.sc);
            end
        end
    end

    initial begin
        //   name          rst v  f  rs  u  rt  u  dst m1  m2  m3  stall tgt
        step("reset_hold",  1, 1, 0,  0, 0,  0, 0,  5,  0,  0,  0,  0,  5);
        step("reset_rel",   0, 1, 0,  0, 0,  0, 0,  5,  0,  0,  0,  0,  5);
        // Minus1 producer
        step("m1_c0",       0, 1, 0,  8, 1,  0, 0,  7,  8,  0,  0,  1,  0);
        step("m1_c1",       0, 1, 0,  8, 1,  0, 0,  7,  0,  8,  0,  1,  0);
`ifdef HAZARD_WB_BYPASS_EN
        step("m1_issue",    0, 1, 0,  8, 1,  0, 0,  7,  0,  0,  8,  0,  7);
`else
        step("m1_c2",       0, 1, 0,  8, 1,  0, 0,  7,  0,  0,  8,  1,  0);
        step("m1_issue",    0, 1, 0,  8, 1,  0, 0,  7,  0,  0,  0,  0,  7);
`endif
        // Minus3 producer on rt
`ifdef HAZARD_WB_BYPASS_EN
        step("m3_nostall",  0, 1, 0,  3, 0,  9, 1,  4,  0,  0,  9,  0,  4);
`else
        step("m3_c0",       0, 1, 0,  3, 0,  9, 1,  4,  0,  0,  9,  1,  0);
        step("m3_issue",    0, 1, 0,  3, 0,  9, 1,  4,  0,  0,  0,  0,  4);
`endif
        step("m3_idle",     0, 1, 0,  3, 0,  9, 1,  2,  0,  0,  0,  0,  2);
        // Register zero and unused sources
        step("r0_nostall",  0, 1, 0,  0, 1,  0, 1,  6,  0,  0,  0,  0,  6);
        step("unused_rt",   0, 1, 0, 11, 1, 10, 0,  6, 10, 12,  0,  0,  6);
        step("invalid",     0, 0, 0,  8, 1,  8, 1,  9,  8,  8,  8,  0,  0);
        // rs on Minus2, rt on Minus1: nearest producer wins
        step("max_c0",      0, 1, 0, 13, 1, 14, 1, 15, 14, 13,  0,  1,  0);
        step("max_c1",      0, 1, 0, 13, 1, 14, 1, 15,  0, 14, 13,  1,  0);
`ifdef HAZARD_WB_BYPASS_EN
        step("max_issue",   0, 1, 0, 13, 1, 14, 1, 15,  0,  0, 14,  0, 15);
`else
        step("max_c2",      0, 1, 0, 13, 1, 14, 1, 15,  0,  0, 14,  1,  0);
        step("max_issue",   0, 1, 0, 13, 1, 14, 1, 15,  0,  0,  0,  0, 15);
`endif
        // Flush during STALL, then IDLE with a clean history
        step("fl_c0",       0, 1, 0,  8, 1,  0, 0,  7,  8,  0,  0,  1,  0);
        step("fl_flush",    0, 1, 1,  8, 1,  0, 0,  7,  0,  8,  0,  0,  0);
        step("fl_idle",     0, 1, 0,  1, 1,  0, 0,  7,  0,  0,  0,  0,  7);
        step("fl_vs_conf",  0, 1, 1, 20, 1,  0, 0,  7, 20,  0,  0,  0,  0);
        step("fl_after",    0, 1, 0,  1, 1,  0, 0,  3,  0,  0,  0,  0,  3);
        // Reset asserted mid-stall
        step("rs_c0",       0, 1, 0, 17, 1,  0, 0,  7, 17,  0,  0,  1,  0);
        step("rs_assert",   1, 0, 0,  0, 0,  0, 0,  0,  0,  0,  0,  0,  0);
        step("rs_release",  0, 1, 0,  1, 1,  0, 0, 22,  0,  0,  0,  0, 22);
        step("rs_after",    0, 1, 0, 19, 1,  0, 0, 22,  0, 19,  0,  1,  0);
`ifdef HAZARD_WB_BYPASS_EN
        step("rs_issue",    0, 1, 0, 19, 1,  0, 0, 22,  0,  0, 19,  0, 22);
`else
        step("rs_c1",       0, 1, 0, 19, 1,  0, 0, 22,  0,  0, 19,  1,  0);
        step("rs_issue",    0, 1, 0, 19, 1,  0, 0, 22,  0,  0,  0,  0, 22);
`endif
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
